// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the
// access-size codes also used by the data cache and load/store buffer.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_BUSY_INS  = 2'b01,
    ST_BUSY_DATA = 2'b10,
    ST_DRAIN_INS = 2'b11
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates the single word-level memory adaptor between the instruction
// refill port and the load/store data port. Data has priority, bounded by a
// streak counter so a pending instruction fetch cannot starve.
//
// state        | meaning
// ST_IDLE      | no access outstanding; grant decision made here
// ST_BUSY_INS  | instruction fetch outstanding at the adaptor
// ST_BUSY_DATA | data load/store outstanding at the adaptor
// ST_DRAIN_INS | flushed fetch still outstanding; result is discarded
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        ins_req,
  input  logic [31:0] ins_addr,
  output logic        ins_done,
  output logic [31:0] ins_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_is_write,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_is_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_is_write_q, mem_is_write_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                ins_done_q, ins_done_d;
  logic [31:0]         ins_rdata_q, ins_rdata_d;
  logic                data_done_q, data_done_d;
  logic [31:0]         data_rdata_q, data_rdata_d;

  logic ins_elig, data_elig, grant_data, grant_ins;

  // A requester whose done is showing this cycle is still holding req for the
  // finished transaction, so it must not be granted again.
  assign ins_elig   = ins_req && !ins_done_q && !flush_pipline;
  assign data_elig  = data_req && !data_done_q;
  assign grant_data = (state_q == ST_IDLE) && data_elig &&
                      !(ins_elig && (streak_q == STREAK_MAX));
  assign grant_ins  = (state_q == ST_IDLE) && ins_elig && !grant_data;

  // Next-state, streak and registered-output computation.
  always_comb begin
    state_d        = state_q;
    streak_d       = streak_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_is_write_d = mem_is_write_q;
    mem_size_d     = mem_size_q;
    mem_wdata_d    = mem_wdata_q;
    ins_done_d     = 1'b0;
    ins_rdata_d    = ins_rdata_q;
    data_done_d    = 1'b0;
    data_rdata_d   = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d        = ST_BUSY_DATA;
          mem_req_d      = 1'b1;
          mem_addr_d     = data_addr;
          mem_is_write_d = data_is_write;
          mem_size_d     = data_size;
          mem_wdata_d    = data_wdata;
        end else if (grant_ins) begin
          state_d        = ST_BUSY_INS;
          mem_req_d      = 1'b1;
          mem_addr_d     = ins_addr;
          mem_is_write_d = 1'b0;
          mem_size_d     = SIZE_WORD;
          mem_wdata_d    = 32'h0;
        end
      end
      ST_BUSY_INS: begin
        if (mem_done) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!flush_pipline) begin
            ins_done_d  = 1'b1;
            ins_rdata_d = mem_rdata;
          end
        end else if (flush_pipline) begin
          state_d = ST_DRAIN_INS;
        end
      end
      ST_BUSY_DATA: begin
        if (mem_done) begin
          state_d      = ST_IDLE;
          mem_req_d    = 1'b0;
          data_done_d  = 1'b1;
          data_rdata_d = mem_rdata;
        end
      end
      ST_DRAIN_INS: begin
        if (mem_done) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (!ins_req || grant_ins) begin
      streak_d = '0;
    end else if (grant_data && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // State and output registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      streak_q       <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= 32'h0;
      mem_is_write_q <= 1'b0;
      mem_size_q     <= 2'b00;
      mem_wdata_q    <= 32'h0;
      ins_done_q     <= 1'b0;
      ins_rdata_q    <= 32'h0;
      data_done_q    <= 1'b0;
      data_rdata_q   <= 32'h0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      streak_q       <= streak_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_is_write_q <= mem_is_write_d;
      mem_size_q     <= mem_size_d;
      mem_wdata_q    <= mem_wdata_d;
      ins_done_q     <= ins_done_d;
      ins_rdata_q    <= ins_rdata_d;
      data_done_q    <= data_done_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_is_write = mem_is_write_q;
  assign mem_size     = mem_size_q;
  assign mem_wdata    = mem_wdata_q;
  assign ins_done     = ins_done_q;
  assign ins_rdata    = ins_rdata_q;
  assign data_done    = data_done_q;
  assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: expected grants and completions are queued when
// stimulus is driven and popped when the DUT raises mem_req or a done pulse.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline;
  logic        ins_req;
  logic [31:0] ins_addr;
  logic        ins_done;
  logic [31:0] ins_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_is_write;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_is_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  memory_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_done(ins_done), .ins_rdata(ins_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_is_write(data_is_write),
    .data_size(data_size), .data_wdata(data_wdata), .data_done(data_done),
    .data_rdata(data_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_is_write(mem_is_write), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk_in = ~clk_in;

  localparam int PORT_NONE = 0;
  localparam int PORT_INS  = 1;
  localparam int PORT_DATA = 2;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    bit          chk_wdata;
  } grant_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } done_t;

  grant_t grant_q[$];
  done_t  done_q[$];
  int     total = 0;
  int     bad = 0;
  logic   prev_mem_req = 1'b0, prev_ins_done = 1'b0, prev_data_done = 1'b0;

  task automatic push_ins_grant(input logic [31:0] addr);
    grant_q.push_back('{addr, 1'b0, SIZE_WORD, 32'h0, 1'b0});
  endtask

  task automatic push_data_grant(input logic [31:0] addr, input logic wr,
                                 input logic [1:0] size, input logic [31:0] wdata);
    grant_q.push_back('{addr, wr, size, wdata, wr});
  endtask

  // Advance one clock, then pop the scoreboard on each new grant/done pulse.
  task automatic tick();
    grant_t g;
    done_t  d;
    @(posedge clk_in);
    #1;
    if (mem_req === 1'b1 && prev_mem_req !== 1'b1) begin
      total++;
      if (grant_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got mem_addr=%h, expected no grant", mem_addr);
      end else begin
        g = grant_q.pop_front();
        if (mem_addr !== g.addr || mem_is_write !== g.wr || mem_size !== g.size ||
            (g.chk_wdata && mem_wdata !== g.wdata)) begin
          bad++;
          $display("FAIL grant_fields: got addr=%h wr=%b size=%b wdata=%h, expected addr=%h wr=%b size=%b wdata=%h",
                   mem_addr, mem_is_write, mem_size, mem_wdata, g.addr, g.wr, g.size, g.wdata);
        end
      end
    end
    if (ins_done === 1'b1 && prev_ins_done !== 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL ins_done_unexpected: got ins_done=1, expected 0");
      end else begin
        d = done_q.pop_front();
        if (d.port != PORT_INS || ins_rdata !== d.rdata) begin
          bad++;
          $display("FAIL ins_done: got port=1 rdata=%h, expected port=%0d rdata=%h", ins_rdata, d.port, d.rdata);
        end
      end
    end
    if (data_done === 1'b1 && prev_data_done !== 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL data_done_unexpected: got data_done=1, expected 0");
      end else begin
        d = done_q.pop_front();
        if (d.port != PORT_DATA || data_rdata !== d.rdata) begin
          bad++;
          $display("FAIL data_done: got port=2 rdata=%h, expected port=%0d rdata=%h", data_rdata, d.port, d.rdata);
        end
      end
    end
    prev_mem_req   = mem_req;
    prev_ins_done  = ins_done;
    prev_data_done = data_done;
  endtask

  // Adaptor model: wait some cycles, then pulse mem_done with rd.
  task automatic serve(input int waits, input logic [31:0] rd, input int port);
    for (int i = 0; i < waits; i++) tick();
    mem_rdata = rd;
    mem_done  = 1'b1;
    if (port != PORT_NONE) done_q.push_back('{port, rd});
    tick();
    mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0;
    ins_req = 1'b0; ins_addr = 32'h0;
    data_req = 1'b0; data_addr = 32'h0; data_is_write = 1'b0;
    data_size = SIZE_WORD; data_wdata = 32'h0;
    mem_rdata = 32'h0; mem_done = 1'b0;
    tick(); tick();
    total++;
    if ({mem_req, mem_is_write, mem_size, ins_done, data_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b, expected 000000", {mem_req, mem_is_write, mem_size, ins_done, data_done});
    end
    total++;
    if ((mem_addr | mem_wdata | ins_rdata | data_rdata) !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got or-of-buses=%h, expected 0", mem_addr | mem_wdata | ins_rdata | data_rdata);
    end
    rst_in = 1'b0;
    tick();
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: got mem_req=%b, expected 0", mem_req); end
  endtask

  task automatic test_ins_only();
    ins_req = 1'b1; ins_addr = 32'h0000_1000;
    push_ins_grant(32'h0000_1000);
    tick();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL ins_grant_latency: got mem_req=%b, expected 1", mem_req); end
    serve(2, 32'h00A0_0093, PORT_INS);
    total++;
    if (ins_done !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL ins_complete: got ins_done=%b mem_req=%b, expected 1 0", ins_done, mem_req);
    end
    tick();
    total++;
    if (mem_req !== 1'b0 || ins_done !== 1'b0) begin
      bad++;
      $display("FAIL ins_no_regrant: got mem_req=%b ins_done=%b, expected 0 0", mem_req, ins_done);
    end
    ins_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    ins_req = 1'b1; ins_addr = 32'h0000_1004;
    data_req = 1'b1; data_addr = 32'h0002_0000; data_is_write = 1'b1;
    data_size = SIZE_WORD; data_wdata = 32'hDEAD_BEEF;
    push_data_grant(32'h0002_0000, 1'b1, SIZE_WORD, 32'hDEAD_BEEF);
    push_ins_grant(32'h0000_1004);
    tick();
    total++;
    if (mem_is_write !== 1'b1) begin bad++; $display("FAIL simul_data_first: got mem_is_write=%b, expected 1", mem_is_write); end
    serve(1, 32'h0, PORT_DATA);
    data_req = 1'b0; data_is_write = 1'b0;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_is_write !== 1'b0) begin
      bad++;
      $display("FAIL simul_ins_after: got mem_req=%b wr=%b, expected 1 0", mem_req, mem_is_write);
    end
    serve(1, 32'h1234_5678, PORT_INS);
    ins_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    ins_req = 1'b1; ins_addr = 32'h0000_3000;
    data_req = 1'b1; data_is_write = 1'b0; data_size = SIZE_WORD;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h400 + 32'(4 * i);
      push_data_grant(data_addr, 1'b0, SIZE_WORD, 32'h0);
      tick();
      serve(1, 32'h100 + 32'(i), PORT_DATA);
      // Keep the instruction port blocked while data's done is showing so the
      // next decision sees both requesters eligible.
      flush_pipline = 1'b1;
      tick();
      flush_pipline = 1'b0;
    end
    push_ins_grant(32'h0000_3000);
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
      bad++;
      $display("FAIL streak_ins_grant: got mem_req=%b addr=%h, expected 1 00003000", mem_req, mem_addr);
    end
    serve(1, 32'hCAFE_0001, PORT_INS);
    data_addr = 32'h500;
    push_data_grant(32'h500, 1'b0, SIZE_WORD, 32'h0);
    tick();
    serve(1, 32'h200, PORT_DATA);
    flush_pipline = 1'b1;
    data_addr = 32'h504;
    tick();
    flush_pipline = 1'b0;
    push_data_grant(32'h504, 1'b0, SIZE_WORD, 32'h0);
    tick();
    total++;
    if (mem_addr !== 32'h504) begin bad++; $display("FAIL streak_cleared: got mem_addr=%h, expected 00000504", mem_addr); end
    serve(1, 32'h201, PORT_DATA);
    ins_req = 1'b0; data_req = 1'b0;
    tick();
  endtask

  task automatic test_flush_ins();
    ins_req = 1'b1; ins_addr = 32'h0000_1100;
    push_ins_grant(32'h0000_1100);
    tick();
    flush_pipline = 1'b1; ins_req = 1'b0;
    tick();
    flush_pipline = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1100) begin
      bad++;
      $display("FAIL drain_hold: got mem_req=%b addr=%h, expected 1 00001100", mem_req, mem_addr);
    end
    serve(1, 32'hBAD0_BAD0, PORT_NONE);
    total++;
    if (ins_done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL drain_end: got ins_done=%b mem_req=%b, expected 0 0", ins_done, mem_req);
    end
    ins_req = 1'b1; ins_addr = 32'h0000_2000;
    push_ins_grant(32'h0000_2000);
    tick();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_after_drain: got mem_req=%b, expected 1", mem_req); end
    serve(1, 32'h1111_1111, PORT_INS);
    ins_req = 1'b0;
    tick();
    ins_req = 1'b1; ins_addr = 32'h0000_2100;
    push_ins_grant(32'h0000_2100);
    tick();
    tick();
    flush_pipline = 1'b1;
    serve(0, 32'hBAD1_BAD1, PORT_NONE);
    flush_pipline = 1'b0; ins_req = 1'b0;
    total++;
    if (ins_done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_with_done: got ins_done=%b mem_req=%b, expected 0 0", ins_done, mem_req);
    end
    tick();
  endtask

  task automatic test_flush_data();
    data_req = 1'b1; data_addr = 32'h0003_0000; data_is_write = 1'b0; data_size = SIZE_BYTE;
    push_data_grant(32'h0003_0000, 1'b0, SIZE_BYTE, 32'h0);
    tick();
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL flush_data_hold: got mem_req=%b, expected 1", mem_req); end
    serve(0, 32'h0000_00FF, PORT_DATA);
    total++;
    if (data_done !== 1'b1 || data_rdata !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL flush_data_done: got done=%b rdata=%h, expected 1 000000ff", data_done, data_rdata);
    end
    data_req = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    data_req = 1'b1; data_addr = 32'h0004_0000; data_is_write = 1'b1;
    data_size = SIZE_HALF; data_wdata = 32'h0000_ABCD;
    push_data_grant(32'h0004_0000, 1'b1, SIZE_HALF, 32'h0000_ABCD);
    tick();
    rdy_in = 1'b0;
    mem_rdata = 32'hDEAD_0000; mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_done = 1'b0;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0004_0000 || data_done !== 1'b0) begin
        bad++;
        $display("FAIL pause_frozen: got req=%b addr=%h done=%b, expected 1 00040000 0", mem_req, mem_addr, data_done);
      end
    end
    rdy_in = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b1 || data_done !== 1'b0) begin
      bad++;
      $display("FAIL pause_pulse_ignored: got req=%b done=%b, expected 1 0", mem_req, data_done);
    end
    serve(0, 32'h0000_0005, PORT_DATA);
    data_req = 1'b0; data_is_write = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ins_req = 1'b1; ins_addr = 32'h0000_5000;
    push_ins_grant(32'h0000_5000);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0; ins_req = 1'b0;
    total++;
    if ({mem_req, mem_is_write, mem_size, ins_done, data_done} !== 6'b0 ||
        (mem_addr | mem_wdata | ins_rdata | data_rdata) !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: got ctrl=%b or-of-buses=%h, expected 0 0",
               {mem_req, mem_is_write, mem_size, ins_done, data_done}, mem_addr | mem_wdata | ins_rdata | data_rdata);
    end
    tick();
    ins_req = 1'b1; ins_addr = 32'h0000_5004;
    push_ins_grant(32'h0000_5004);
    tick();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_then_idle: got mem_req=%b, expected 1", mem_req); end
    serve(1, 32'h0000_0077, PORT_INS);
    ins_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ins_only();
    test_simultaneous();
    test_starvation();
    test_flush_ins();
    test_flush_data();
    test_pause();
    test_reset_mid();
    total++;
    if (grant_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got grants=%0d dones=%0d left, expected 0 0", grant_q.size(), done_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Shares the single word-level memory adaptor between two requesters: the instruction cache refill path (instruction port) and the load/store buffer (data port). Data has priority, with a bounded-streak rule so instruction fetch cannot starve. On pipeline flush, an instruction fetch already in flight is drained silently. Data accesses are non-speculative and are always completed.

Parameters:
MAX_DATA_STREAK, 4, maximum number of consecutive data grants while an instruction request is pending; the next grant then goes to the instruction port.

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global pause; when low all state holds
flush_pipline  in  1  pipeline flush pulse
ins_req  in  1  instruction fetch request, level; held until ins_done
ins_addr  in  32  instruction fetch address, stable while ins_req
ins_done  out  1  one-cycle pulse: ins_rdata valid
ins_rdata  out  32  fetched word
data_req  in  1  data access request, level; held until data_done
data_addr  in  32  data address, stable while data_req
data_is_write  in  1  1 = store
data_size  in  2  00 byte, 01 half, 10 word (11 illegal)
data_wdata  in  32  store data, low bytes used
data_done  out  1  one-cycle pulse: access complete; data_rdata valid for loads
data_rdata  out  32  raw load data, zero-extended; sign extension is done by the requester
mem_req  out  1  request to adaptor, held until mem_done
mem_addr  out  32  adaptor address
mem_is_write  out  1  adaptor write enable
mem_size  out  2  adaptor access size
mem_wdata  out  32  adaptor store data
mem_rdata  in  32  adaptor read data, valid with mem_done
mem_done  in  1  adaptor completion pulse

Behaviour:
- States: IDLE, BUSY_INS, BUSY_DATA, DRAIN_INS. All outputs are registered.
- Reset: state IDLE, streak counter 0, and every output 0.
- rdy_in low: state, counter and all outputs hold; mem_done and requests are not sampled.
- Grant rules (IDLE only):
  - Eligible requesters are those whose request is high and whose done output is not high this cycle, so the same transaction is never re-granted.
  - instruction is eligible only if flush_pipline is low.
  - If both are eligible: data wins unless streak == MAX_DATA_STREAK.
  - Grant in cycle N: next state is BUSY_x, with mem_req=1 and mem_addr/is_write/size/wdata latched in cycle N+1.
  - Instruction grants force mem_is_write=0 and mem_size=10.
- Streak counter:
  - Increments on a data grant while ins_req is high, saturating at MAX_DATA_STREAK.
  - Clears on an instruction grant, or in any cycle ins_req is low.
- BUSY_x with mem_done in cycle M:
  - mem_req=0 and state IDLE in M+1.
  - The matching done output pulses in M+1, with rdata = mem_rdata latched in cycle M.
  - The earliest next mem_req is M+2.
- mem_req and the mem_* fields stay constant for the whole of a BUSY or DRAIN state.
- Flush:
  - BUSY_INS with flush_pipline → DRAIN_INS, with mem_req kept high. On mem_done → IDLE, and ins_done is never pulsed.
  - flush_pipline together with mem_done in BUSY_INS: go to IDLE and suppress ins_done.
  - Flush has no effect in BUSY_DATA.
  - Flush in IDLE blocks only the instruction grant for that cycle.
- A requester dropping its req mid-transaction is illegal and is not checked; the transaction still completes.
- data_size 11 is forwarded unchanged. Detecting it is the adaptor's job.

Decomposition:
- Shared package: state encoding (IDLE, BUSY_INS, BUSY_DATA, DRAIN_INS) and size constants (SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10). The data cache/LSB reuse the size constants.
- No sub-module. The arbiter is a single FSM plus a streak counter.

Test Plan:
- Instruction-only: ins_req, ins_addr=0x1000; adaptor returns 0x00A00093 after 3 cycles. Expect mem_req 1 cycle after the request, ins_done exactly once with ins_rdata=0x00A00093, and no regrant in the done cycle.
- Simultaneous: ins_req and data_req (store, addr 0x20000, size 10, wdata 0xDEADBEEF) in the same cycle. Expect the data grant first with mem_is_write=1; the instruction is granted after data_done.
- Starvation: data_req re-asserted continuously with MAX_DATA_STREAK=4 and ins_req held. Expect exactly 4 data grants, then 1 instruction grant, then the counter back at 0.
- Flush: flush in BUSY_INS with mem_done 2 cycles later. Expect mem_req held through drain, no ins_done, and a new fetch to 0x2000 granted afterwards. Repeat with flush in the same cycle as mem_done: ins_done suppressed.
- Flush during BUSY_DATA (load, size 00, mem_rdata 0x000000FF). Expect data_done with data_rdata=0x000000FF and unaffected timing.
- Pause: drop rdy_in for 3 cycles mid-BUSY_DATA with mem_done pulsed while paused. Expect outputs frozen and the pulse ignored. Reset mid-transaction: all outputs 0 in the next cycle, state IDLE.
